kv_repl_ctrl: RTL and testbench
===============================

Name: kv_repl_ctrl

Overview:
- Parametrised replacement-policy controller for the set-associative L1 caches.
- Keeps per-set recency state. Selects policy by parameter: true-LRU age matrix or tree pseudo-LRU.
- Returns a registered one-hot victim that prefers invalid ways and skips locked ways.
- Includes a set-sweeping init/flush engine. Sits beside the tag arrays; the cache FSM issues touches on hit/fill and victim requests on miss.

Parameters:
- WAY_NUM, 4, associativity; power of two, 2..16.
- SET_NUM, 16, number of sets; power of two, >=2.
- POLICY, 0, 0 = matrix true-LRU, 1 = tree PLRU.
- INDEX_WIDTH, $clog2(SET_NUM), localparam.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_flush  in  1  pulse: re-initialise all sets
- o_ready  out  1  1 = init done, requests accepted
- i_touch_valid  in  1  access update strobe (hit or fill)
- i_touch_index  in  INDEX_WIDTH  set being touched
- i_touch_way  in  WAY_NUM  one-hot way touched
- i_victim_req  in  1  victim query strobe
- i_victim_index  in  INDEX_WIDTH  set queried
- i_valid_way  in  WAY_NUM  valid bits of the queried set
- i_lock_way  in  WAY_NUM  ways excluded from replacement
- o_victim_valid  out  1  victim result strobe
- o_victim_way  out  WAY_NUM  one-hot victim
- o_victim_none  out  1  all ways locked, no victim

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rstn.
- Reset values: o_ready=0, o_victim_valid=0, o_victim_way=0, o_victim_none=0. FSM=INIT, init counter=0.
- FSM states:
  - INIT: writes the initial state to set[cnt], then cnt++. After set SET_NUM-1 it goes to RUN, so init takes exactly SET_NUM cycles. o_ready goes 1 on the first RUN cycle.
  - RUN: o_ready=1.
  - i_flush=1 in any state: go to INIT, cnt=0, o_ready=0 next cycle. Flush during INIT restarts the sweep.
- Requests while o_ready=0: touches and victim requests are ignored; o_victim_valid stays 0.
- Matrix mode storage:
  - Each set holds WAY_NUM x WAY_NUM bits. M[i][j]=1 means way i was used more recently than way j; the diagonal is always 0.
  - Touch way w: row w gets all 1s except the diagonal; column w is cleared.
  - Initial state: M[i][j]=1 iff i>j, so way0 is LRU and way WAY_NUM-1 is MRU.
- PLRU mode storage:
  - Each set holds WAY_NUM-1 tree bits; bit=0 points left (lower ways).
  - Touch way w: every node on w's path is set to point away from w.
  - Initial state: all bits 0, so the victim is way0.
- Touch rules:
  - The update is written at the next edge.
  - i_touch_way zero or multi-hot: the touch is ignored and state is unchanged.
- Victim selection: combinational from state, result registered, 1-cycle latency. A request in cycle N gives o_victim_valid=1 in cycle N+1 only. Candidates are C = ~i_lock_way. Priority:
  - (1) lowest-index way in C with valid=0;
  - (2) matrix mode: the way w in C whose M[w][j]=0 for every other j in C;
  - (2) PLRU mode: the tree victim if it is in C, else the lowest-index way in C;
  - (3) C empty: o_victim_way=0, o_victim_none=1.
- o_victim_none is 0 whenever a victim exists.
- Simultaneous touch and victim request on the same index: the victim uses the pre-touch state (read-before-write); the touch is still applied.
- Back-to-back victim requests are accepted every cycle; the victim path does not modify state. The caller must issue a touch for the fill.
- Index wrap: indices are full-width, so no out-of-range case exists.

Decomposition:
- Shared package kv_cache_pkg holds:
  - the policy enum (KV_REPL_LRU=0, KV_REPL_PLRU=1);
  - the init-FSM state enum (INIT, RUN);
  - functions onehot_to_idx and lowest_set_onehot, shared with the tag and way-select logic.
- One sub-module: kv_repl_pick. It is purely combinational: state row, valid mask, lock mask and policy in; one-hot victim and none flag out. It is used once and unit-testable on its own.
- Storage and the init FSM stay in kv_repl_ctrl.

Test Plan:
- Reset and init: deassert i_rstn with SET_NUM=16 -> o_ready=0 for exactly 16 cycles, 1 on cycle 17. A victim request during init -> o_victim_valid stays 0.
- LRU order (POLICY=0, WAY_NUM=4, all valid, no locks): touch set 3 with ways 0, 2, 1, 3 in order, then request set 3 -> o_victim_way=4'b0001 one cycle later. Touch way0, request again -> 4'b0100.
- Invalid and lock priority: valid=4'b1011, lock=0 -> victim 4'b0100. Valid=4'b1111, lock=4'b0001 after the initial state -> matrix victim 4'b0010. Lock=4'b1111 -> o_victim_none=1, o_victim_way=0.
- PLRU (POLICY=1, WAY_NUM=4): after init, touch way0 -> victim way2 (4'b0100). Touch way2 -> victim way1 (4'b0010).
- Same-cycle hazard: set 5 in initial state; touch way0 and request set 5 in the same cycle -> victim 4'b0001. The next request -> 4'b0010.
- Flush: after populating several sets, pulse i_flush -> o_ready=0 for 16 cycles, then every set returns victim 4'b0001. Zero or multi-hot touches (4'b0000, 4'b0110) -> state unchanged.

Source files
------------

// File: rtl/kv_cache_pkg.sv
// Purpose: shared L1 cache types and one-hot helpers for replacement and way-select logic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: policy enum, init-FSM state enum, onehot_to_idx, lowest_set_onehot, repl_row_w.
package kv_cache_pkg;

    typedef enum int {
        KV_REPL_LRU  = 0,
        KV_REPL_PLRU = 1
    } kv_repl_policy_e;

    typedef enum logic [0:0] {
        KV_INIT = 1'b0,
        KV_RUN  = 1'b1
    } kv_init_state_e;

    // Helpers work on the widest supported associativity; callers size-cast.
    localparam int KV_MAX_WAYS  = 16;
    localparam int KV_MAX_IDX_W = 4;

    function automatic logic [KV_MAX_IDX_W-1:0] onehot_to_idx(input logic [KV_MAX_WAYS-1:0] oh);
        logic [KV_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KV_MAX_WAYS; i++) begin
            if (oh[i]) idx = idx | KV_MAX_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [KV_MAX_WAYS-1:0] lowest_set_onehot(input logic [KV_MAX_WAYS-1:0] v);
        return v & (~v + KV_MAX_WAYS'(1));
    endfunction

    // Bits of recency state per set: full age matrix or PLRU tree.
    function automatic int repl_row_w(input int ways, input int policy);
        return (policy == int'(KV_REPL_PLRU)) ? ways - 1 : ways * ways;
    endfunction

endpackage

// File: rtl/kv_repl_pick.sv
// Purpose: combinational victim pick from one set's recency row, valid mask and lock mask.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, the caller decides when to register the result.
// Ports: i_row (recency state), i_valid_way, i_lock_way in; o_victim_way (one-hot), o_victim_none out.
module kv_repl_pick
    import kv_cache_pkg::*;
#(
    parameter int WAY_NUM = 4,
    parameter int POLICY  = 0,
    localparam int ROW_W  = repl_row_w(WAY_NUM, POLICY)
) (
    input  logic [ROW_W-1:0]   i_row,
    input  logic [WAY_NUM-1:0] i_valid_way,
    input  logic [WAY_NUM-1:0] i_lock_way,
    output logic [WAY_NUM-1:0] o_victim_way,
    output logic               o_victim_none
);

    localparam int WIDX = $clog2(WAY_NUM);

    logic [WAY_NUM-1:0] cand;
    logic [WAY_NUM-1:0] free;
    logic [WAY_NUM-1:0] pol_pick;

    assign cand = ~i_lock_way;
    assign free = cand & ~i_valid_way;

    generate
        if (POLICY == int'(KV_REPL_PLRU)) begin : g_plru
            logic [WAY_NUM-1:0] tree_oh;
            int                 node;
            int                 way;
            logic               dir;

            always_comb begin
                node    = 0;
                way     = 0;
                dir     = 1'b0;
                tree_oh = '0;
                // Walk root to leaf following the bits; the path spells the way index MSB first.
                for (int l = 0; l < WIDX; l++) begin
                    dir = 1'b0;
                    for (int n = 0; n < WAY_NUM - 1; n++) begin
                        if (n == node) dir = i_row[n];
                    end
                    way  = way * 2 + int'(dir);
                    node = node * 2 + 1 + int'(dir);
                end
                for (int w = 0; w < WAY_NUM; w++) begin
                    tree_oh[w] = (w == way);
                end
                // A locked tree victim falls back to the lowest unlocked way.
                pol_pick = (|(tree_oh & cand)) ? tree_oh
                                               : WAY_NUM'(lowest_set_onehot(KV_MAX_WAYS'(cand)));
            end
        end else begin : g_lru
            logic [WAY_NUM-1:0] oldest;

            always_comb begin
                // A candidate is oldest when it is newer than no other candidate.
                for (int w = 0; w < WAY_NUM; w++) begin
                    oldest[w] = cand[w];
                    for (int j = 0; j < WAY_NUM; j++) begin
                        if (j != w && cand[j] && i_row[w*WAY_NUM+j]) oldest[w] = 1'b0;
                    end
                end
                pol_pick = WAY_NUM'(lowest_set_onehot(KV_MAX_WAYS'(oldest)));
            end
        end
    endgenerate

    always_comb begin
        o_victim_way  = '0;
        o_victim_none = 1'b0;
        if (|free) begin
            o_victim_way = WAY_NUM'(lowest_set_onehot(KV_MAX_WAYS'(free)));
        end else if (cand == '0) begin
            o_victim_none = 1'b1;
        end else begin
            o_victim_way = pol_pick;
        end
    end

endmodule

// File: rtl/kv_repl_ctrl.sv
// Purpose: per-set replacement state (LRU matrix or PLRU tree) with init/flush sweep and victim query.
// Latency: victim result 1 cycle after request; touch visible from the next cycle; init/flush SET_NUM cycles.
// Backpressure: o_ready=0 during the sweep, requests then dropped; in RUN a request is accepted every cycle.
// Ports: i_clk, i_rstn (sync, active-low), i_flush, o_ready; touch i_touch_valid/index/way;
//        victim i_victim_req/index, i_valid_way, i_lock_way -> o_victim_valid, o_victim_way, o_victim_none.
module kv_repl_ctrl
    import kv_cache_pkg::*;
#(
    parameter int WAY_NUM       = 4,
    parameter int SET_NUM       = 16,
    parameter int POLICY        = 0,
    localparam int INDEX_WIDTH  = $clog2(SET_NUM)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_flush,
    output logic                   o_ready,
    input  logic                   i_touch_valid,
    input  logic [INDEX_WIDTH-1:0] i_touch_index,
    input  logic [WAY_NUM-1:0]     i_touch_way,
    input  logic                   i_victim_req,
    input  logic [INDEX_WIDTH-1:0] i_victim_index,
    input  logic [WAY_NUM-1:0]     i_valid_way,
    input  logic [WAY_NUM-1:0]     i_lock_way,
    output logic                   o_victim_valid,
    output logic [WAY_NUM-1:0]     o_victim_way,
    output logic                   o_victim_none
);

    localparam int         ROW_W   = repl_row_w(WAY_NUM, POLICY);
    localparam int         WIDX    = $clog2(WAY_NUM);
    localparam logic [0:0] ST_INIT = KV_INIT;
    localparam logic [0:0] ST_RUN  = KV_RUN;

    logic [0:0]             state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   vict_vld_q, vict_vld_d;
    logic [WAY_NUM-1:0]     vict_way_q, vict_way_d;
    logic                   vict_none_q, vict_none_d;

    logic [ROW_W-1:0]       mem_q [SET_NUM];
    logic                   mem_we;
    logic [INDEX_WIDTH-1:0] mem_wa;
    logic [ROW_W-1:0]       mem_wd;

    logic [ROW_W-1:0]       init_row;
    logic [ROW_W-1:0]       touch_row_cur;
    logic [ROW_W-1:0]       touch_row;
    logic [WIDX-1:0]        touch_idx;
    logic [WAY_NUM-1:0]     pick_way;
    logic                   pick_none;

    assign touch_idx     = WIDX'(onehot_to_idx(KV_MAX_WAYS'(i_touch_way)));
    assign touch_row_cur = mem_q[i_touch_index];

    generate
        if (POLICY == int'(KV_REPL_PLRU)) begin : g_plru
            int   node;
            logic dir;

            always_comb begin
                init_row  = '0;
                touch_row = touch_row_cur;
                node      = 0;
                dir       = 1'b0;
                // Every node on the touched way's path is turned to point away from it.
                for (int l = 0; l < WIDX; l++) begin
                    dir = touch_idx[WIDX-1-l];
                    for (int n = 0; n < WAY_NUM - 1; n++) begin
                        if (n == node) touch_row[n] = ~dir;
                    end
                    node = node * 2 + 1 + int'(dir);
                end
            end
        end else begin : g_lru
            always_comb begin
                init_row  = '0;
                touch_row = touch_row_cur;
                // Column clear wins over row set, which keeps the diagonal at zero.
                for (int i = 0; i < WAY_NUM; i++) begin
                    for (int j = 0; j < WAY_NUM; j++) begin
                        init_row[i*WAY_NUM+j] = (i > j);
                        if (j == int'(touch_idx)) begin
                            touch_row[i*WAY_NUM+j] = 1'b0;
                        end else if (i == int'(touch_idx)) begin
                            touch_row[i*WAY_NUM+j] = 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Reads the pre-write row, so a same-cycle touch never affects this victim.
    kv_repl_pick #(
        .WAY_NUM (WAY_NUM),
        .POLICY  (POLICY)
    ) u_pick (
        .i_row         (mem_q[i_victim_index]),
        .i_valid_way   (i_valid_way),
        .i_lock_way    (i_lock_way),
        .o_victim_way  (pick_way),
        .o_victim_none (pick_none)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = i_touch_index;
        mem_wd  = touch_row;
        if (state_q == ST_INIT) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = init_row;
            cnt_d  = cnt_q + INDEX_WIDTH'(1);
            if (cnt_q == INDEX_WIDTH'(SET_NUM - 1)) state_d = ST_RUN;
        end else if (i_touch_valid && $onehot(i_touch_way)) begin
            mem_we = 1'b1;
        end
        if (i_flush) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            mem_we  = 1'b0;
        end
    end

    always_comb begin
        vict_vld_d  = (state_q == ST_RUN) && i_victim_req;
        vict_way_d  = vict_vld_d ? pick_way : '0;
        vict_none_d = vict_vld_d && pick_none;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            vict_vld_q  <= 1'b0;
            vict_way_q  <= '0;
            vict_none_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vict_vld_q  <= vict_vld_d;
            vict_way_q  <= vict_way_d;
            vict_none_q <= vict_none_d;
        end
    end

    // Contents need no reset: the sweep rewrites every set before requests are accepted.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign o_ready        = (state_q == ST_RUN);
    assign o_victim_valid = vict_vld_q;
    assign o_victim_way   = vict_way_q;
    assign o_victim_none  = vict_none_q;

endmodule

// File: tb/tb_kv_repl_ctrl.sv
// Purpose: scoreboard bench for kv_repl_ctrl, one LRU instance (a) and one PLRU instance (b).
// Latency: expects each victim exactly one cycle after its request.
// Backpressure: requests are only issued while o_ready=1, except deliberate drops during init.
module tb_kv_repl_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       flush;
    logic [3:0] t_idx, v_idx;
    logic [3:0] t_way, valid_way, lock_way;
    logic       tv_a, tv_b, vr_a, vr_b;
    logic       rdy_a, rdy_b, vv_a, vv_b, vn_a, vn_b;
    logic [3:0] vw_a, vw_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] way;
        logic       none;
        int         cyc;
        int         id;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kv_repl_ctrl #(.WAY_NUM(4), .SET_NUM(16), .POLICY(0)) u_lru (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .o_ready(rdy_a),
        .i_touch_valid(tv_a), .i_touch_index(t_idx), .i_touch_way(t_way),
        .i_victim_req(vr_a), .i_victim_index(v_idx), .i_valid_way(valid_way), .i_lock_way(lock_way),
        .o_victim_valid(vv_a), .o_victim_way(vw_a), .o_victim_none(vn_a)
    );

    kv_repl_ctrl #(.WAY_NUM(4), .SET_NUM(16), .POLICY(1)) u_plru (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .o_ready(rdy_b),
        .i_touch_valid(tv_b), .i_touch_index(t_idx), .i_touch_way(t_way),
        .i_victim_req(vr_b), .i_victim_index(v_idx), .i_valid_way(valid_way), .i_lock_way(lock_way),
        .o_victim_valid(vv_b), .o_victim_way(vw_b), .o_victim_none(vn_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per valid result and checks content and timing.
    always @(negedge clk) begin
        if (vv_a) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_valid: got way=%b none=%b required no result", vw_a, vn_a);
            end else begin
                ea = qa.pop_front();
                chk($sformatf("a_v%0d_way", ea.id), 32'(vw_a), 32'(ea.way));
                chk($sformatf("a_v%0d_none", ea.id), 32'(vn_a), 32'(ea.none));
                chk($sformatf("a_v%0d_cycle", ea.id), cyc, ea.cyc);
            end
        end
        if (vv_b) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_valid: got way=%b none=%b required no result", vw_b, vn_b);
            end else begin
                eb = qb.pop_front();
                chk($sformatf("b_v%0d_way", eb.id), 32'(vw_b), 32'(eb.way));
                chk($sformatf("b_v%0d_none", eb.id), 32'(vn_b), 32'(eb.none));
                chk($sformatf("b_v%0d_cycle", eb.id), cyc, eb.cyc);
            end
        end
    end

    // Drive tasks start and end 1 time unit after a rising edge.
    task automatic touch(input int sel, input logic [3:0] idx, input logic [3:0] way);
        t_idx = idx; t_way = way;
        if (sel == 0) tv_a = 1'b1; else tv_b = 1'b1;
        @(posedge clk); #1;
        tv_a = 1'b0; tv_b = 1'b0;
    endtask

    task automatic push_req(input int sel, input logic [3:0] idx, input logic [3:0] vld,
                            input logic [3:0] lck, input logic [3:0] ew, input logic en, input int id);
        exp_t e;
        e.way = ew; e.none = en; e.cyc = cyc + 1; e.id = id;
        v_idx = idx; valid_way = vld; lock_way = lck;
        if (sel == 0) begin qa.push_back(e); vr_a = 1'b1; end
        else          begin qb.push_back(e); vr_b = 1'b1; end
    endtask

    task automatic req(input int sel, input logic [3:0] idx, input logic [3:0] vld,
                       input logic [3:0] lck, input logic [3:0] ew, input logic en, input int id);
        push_req(sel, idx, vld, lck, ew, en, id);
        @(posedge clk); #1;
        vr_a = 1'b0; vr_b = 1'b0;
    endtask

    task automatic touch_and_req(input int sel, input logic [3:0] idx, input logic [3:0] way,
                                 input logic [3:0] ew, input int id);
        t_idx = idx; t_way = way;
        if (sel == 0) tv_a = 1'b1; else tv_b = 1'b1;
        push_req(sel, idx, 4'hF, 4'h0, ew, 1'b0, id);
        @(posedge clk); #1;
        tv_a = 1'b0; tv_b = 1'b0; vr_a = 1'b0; vr_b = 1'b0;
    endtask

    // Entered just after the edge that starts the sweep: ready low for 16 samples, high on the 17th.
    task automatic init_window(input string tag, input bit drop_req);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("%s_ready_a_c%0d", tag, i), 32'(rdy_a), 32'd0);
            chk($sformatf("%s_ready_b_c%0d", tag, i), 32'(rdy_b), 32'd0);
            chk($sformatf("%s_vvalid_a_c%0d", tag, i), 32'(vv_a), 32'd0);
            chk($sformatf("%s_vvalid_b_c%0d", tag, i), 32'(vv_b), 32'd0);
            v_idx = 4'd0; valid_way = 4'hF; lock_way = 4'h0;
            vr_a  = drop_req && (i == 2 || i == 3);
            tv_a  = drop_req && (i == 4);
            t_idx = 4'd0; t_way = 4'b0001;
            @(posedge clk);
        end
        vr_a = 1'b0; tv_a = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_ready_a_done", tag), 32'(rdy_a), 32'd1);
        chk($sformatf("%s_ready_b_done", tag), 32'(rdy_b), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0;
        t_idx = '0; v_idx = '0; t_way = '0; valid_way = 4'hF; lock_way = '0;
        tv_a = 1'b0; tv_b = 1'b0; vr_a = 1'b0; vr_b = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", 32'(rdy_a), 32'd0);
        chk("rst_valid_a", 32'(vv_a), 32'd0);
        chk("rst_way_a", 32'(vw_a), 32'd0);
        chk("rst_none_a", 32'(vn_a), 32'd0);
        chk("rst_ready_b", 32'(rdy_b), 32'd0);
        chk("rst_valid_b", 32'(vv_b), 32'd0);

        @(posedge clk); #1;
        rstn = 1'b1;
        init_window("reset", 1'b1);
        @(posedge clk); #1;

        // LRU order on set 3 (the dropped init touch of set 0 must not matter).
        touch(0, 3, 4'b0001); touch(0, 3, 4'b0100); touch(0, 3, 4'b0010); touch(0, 3, 4'b1000);
        req(0, 3, 4'hF, 4'h0, 4'b0001, 1'b0, 1);
        touch(0, 3, 4'b0001);
        req(0, 3, 4'hF, 4'h0, 4'b0100, 1'b0, 2);
        req(0, 0, 4'hF, 4'h0, 4'b0001, 1'b0, 3);
        // Invalid-way priority beats recency.
        req(0, 3, 4'b1011, 4'h0, 4'b0100, 1'b0, 4);
        req(0, 3, 4'b1110, 4'h0, 4'b0001, 1'b0, 5);
        // Locks on an initial-state set.
        req(0, 7, 4'hF, 4'b0001, 4'b0010, 1'b0, 6);
        req(0, 7, 4'hF, 4'b1111, 4'b0000, 1'b1, 7);
        req(0, 7, 4'b0000, 4'b0001, 4'b0010, 1'b0, 8);
        // Same-cycle touch and request: read-before-write.
        touch_and_req(0, 5, 4'b0001, 4'b0001, 9);
        req(0, 5, 4'hF, 4'h0, 4'b0010, 1'b0, 10);
        // Zero and multi-hot touches are ignored.
        touch(0, 5, 4'b0000); touch(0, 5, 4'b0110);
        req(0, 5, 4'hF, 4'h0, 4'b0010, 1'b0, 11);
        // Back-to-back requests on different sets.
        req(0, 3, 4'hF, 4'h0, 4'b0100, 1'b0, 12);
        req(0, 7, 4'hF, 4'h0, 4'b0001, 1'b0, 13);

        // PLRU tree on set 2 and set 9.
        req(1, 2, 4'hF, 4'h0, 4'b0001, 1'b0, 20);
        touch(1, 2, 4'b0001);
        req(1, 2, 4'hF, 4'h0, 4'b0100, 1'b0, 21);
        touch(1, 2, 4'b0100);
        req(1, 2, 4'hF, 4'h0, 4'b0010, 1'b0, 22);
        req(1, 9, 4'hF, 4'b0001, 4'b0010, 1'b0, 23);
        req(1, 9, 4'b0111, 4'h0, 4'b1000, 1'b0, 24);
        req(1, 9, 4'hF, 4'b1111, 4'b0000, 1'b1, 25);

        // Flush returns every set to its initial state.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        init_window("flush", 1'b0);
        @(posedge clk); #1;
        req(0, 3, 4'hF, 4'h0, 4'b0001, 1'b0, 30);
        req(0, 5, 4'hF, 4'h0, 4'b0001, 1'b0, 31);
        req(0, 15, 4'hF, 4'h0, 4'b0001, 1'b0, 32);
        req(1, 2, 4'hF, 4'h0, 4'b0001, 1'b0, 33);
        req(1, 15, 4'hF, 4'h0, 4'b0001, 1'b0, 34);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_pending_results", qa.size(), 32'd0);
        chk("b_pending_results", qb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
